tdc_capture: RTL and testbench

- Launch/capture controller directly downstream of the TDC delay line: drives the line's input edge, samples the N-tap thermometer output on the next clock edge, and synchronizes it.
- Converts the sample to a bubble-tolerant binary tap count.
- Presents each result on a valid/ready interface to the readout logic.
- One measurement in flight at a time; the line is drained before re-arming.

---
 rtl/tdc_pkg.sv | 27 ++
 rtl/tdc_capture_if.sv | 39 +++
 rtl/tdc_therm2bin.sv | 52 +++++
 rtl/tdc_capture.sv | 179 +++++++++++++++++
 tb/tb_tdc_capture.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tdc_pkg.sv
// -----------------------------------------------------------------------------
// tdc_pkg
// Shared types and defaults for the TDC launch/capture controller.
//   tdc_cap_state_e  : capture FSM state encoding
//   tdc_out_w()      : width needed to hold a tap count of 0..N
//   TDC_*_DEFAULT    : default tap count, sync depth and relax length
// -----------------------------------------------------------------------------
package tdc_pkg;

    localparam int TDC_N_DEFAULT     = 64;
    localparam int TDC_SYNC_DEFAULT  = 2;
    localparam int TDC_RELAX_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_SYNC   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RELAX  = 3'd4
    } tdc_cap_state_e;

    // Width of a count that must represent every value from 0 up to n.
    function automatic int tdc_out_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tdc_capture_if.sv
// -----------------------------------------------------------------------------
// tdc_capture_if
// Result channel from the capture controller to the readout logic.
//   meas       : tap count (0..N)
//   meas_valid : meas/overflow/bubble_err are valid
//   meas_ready : consumer accepts the result
//   overflow   : every tap was set
//   bubble_err : sample was not a clean thermometer code
// Modports: master = controller side, slave = readout side.
// -----------------------------------------------------------------------------
interface tdc_capture_if
    import tdc_pkg::*;
#(
    parameter int OUT_W = tdc_out_w(TDC_N_DEFAULT)
);

    logic [OUT_W-1:0] meas;
    logic             meas_valid;
    logic             meas_ready;
    logic             overflow;
    logic             bubble_err;

    modport master (
        output meas,
        output meas_valid,
        output overflow,
        output bubble_err,
        input  meas_ready
    );

    modport slave (
        input  meas,
        input  meas_valid,
        input  overflow,
        input  bubble_err,
        output meas_ready
    );

endinterface

// File: rtl/tdc_therm2bin.sv
// -----------------------------------------------------------------------------
// tdc_therm2bin
// Purely combinational thermometer-to-binary converter for a TDC sample.
//   code     (in,  N)     : synchronized tap sample
//   count    (out, OUT_W) : number of ones after optional inversion
//   overflow (out, 1)     : all N taps set
//   bubble   (out, 1)     : some tap i is 1 while tap i-1 is 0
// INVERT=1 treats the taps as active-low. Counting ones instead of locating
// the first zero keeps the count meaningful in the presence of bubbles.
// -----------------------------------------------------------------------------
module tdc_therm2bin
    import tdc_pkg::*;
#(
    parameter int N      = TDC_N_DEFAULT,
    parameter int OUT_W  = tdc_out_w(N),
    parameter int INVERT = 0
) (
    input  logic [N-1:0]     code,
    output logic [OUT_W-1:0] count,
    output logic             overflow,
    output logic             bubble
);

    logic [N-1:0]     taps_s;
    logic [OUT_W-1:0] pop_s;
    logic             bub_s;

    // Normalise polarity, then popcount at OUT_W and scan for bubbles.
    always_comb begin
        taps_s = (INVERT != 0) ? ~code : code;
        pop_s  = {OUT_W{1'b0}};
        bub_s  = 1'b0;
        for (int i = 0; i < N; i++) begin
            pop_s = pop_s + OUT_W'(taps_s[i]);
        end
        for (int i = 1; i < N; i++) begin
            bub_s = bub_s | (taps_s[i] & ~taps_s[i-1]);
        end
    end

    // Saturate at N and flag a fully overrun line.
    always_comb begin
        if (pop_s > OUT_W'(N)) begin
            count = OUT_W'(N);
        end else begin
            count = pop_s;
        end
        overflow = (pop_s == OUT_W'(N));
        bubble   = bub_s;
    end

endmodule

// File: rtl/tdc_capture.sv
// -----------------------------------------------------------------------------
// tdc_capture
// Launch/capture controller sitting right after the TDC delay line.
//   clk, rst_n : system clock, asynchronous active-low reset
//   ena        : start is ignored while low (does not abort a measurement)
//   start      : measurement request, honoured only in IDLE
//   launch     : registered edge driven into the delay line
//   dl_out     : raw asynchronous thermometer taps
//   busy       : FSM is not in IDLE
//   res        : result channel (meas, overflow, bubble_err, valid/ready)
// Sequence: IDLE -> LAUNCH (1 cycle) -> SYNC (SYNC_STAGES cycles) -> HOLD
// (until accepted) -> RELAX (RELAX_CYC cycles, launch low so the line drains)
// -> IDLE. One measurement is in flight at a time.
// -----------------------------------------------------------------------------
module tdc_capture
    import tdc_pkg::*;
#(
    parameter int N           = TDC_N_DEFAULT,
    parameter int OUT_W       = tdc_out_w(N),
    parameter int SYNC_STAGES = TDC_SYNC_DEFAULT,
    parameter int RELAX_CYC   = TDC_RELAX_DEFAULT,
    parameter int INVERT      = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          start,
    output logic          launch,
    input  logic [N-1:0]  dl_out,
    output logic          busy,
    tdc_capture_if.master res
);

    localparam int SC_W = $clog2(SYNC_STAGES);
    localparam int RC_W = (RELAX_CYC > 1) ? $clog2(RELAX_CYC) : 1;

    tdc_cap_state_e   state_q, state_d;
    logic             launch_q, launch_d;
    logic             valid_q, valid_d;
    logic [OUT_W-1:0] meas_q, meas_d;
    logic             ovf_q, ovf_d;
    logic             bub_q, bub_d;
    logic             busy_q, busy_d;
    logic [SC_W-1:0]  sync_cnt_q, sync_cnt_d;
    logic [RC_W-1:0]  relax_cnt_q, relax_cnt_d;

    // Stage 0 is the capture flop that samples the asynchronous taps; the
    // remaining stages resolve metastability before encoding.
    logic [N-1:0]     sync_q [SYNC_STAGES];

    logic [OUT_W-1:0] enc_count_s;
    logic             enc_ovf_s;
    logic             enc_bub_s;

    // Capture and synchronizer chain on the delay-line taps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= {N{1'b0}};
            end
        end else begin
            sync_q[0] <= dl_out;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    tdc_therm2bin #(
        .N      (N),
        .OUT_W  (OUT_W),
        .INVERT (INVERT)
    ) u_therm2bin (
        .code     (sync_q[SYNC_STAGES-1]),
        .count    (enc_count_s),
        .overflow (enc_ovf_s),
        .bubble   (enc_bub_s)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            launch_q    <= 1'b0;
            valid_q     <= 1'b0;
            meas_q      <= {OUT_W{1'b0}};
            ovf_q       <= 1'b0;
            bub_q       <= 1'b0;
            busy_q      <= 1'b0;
            sync_cnt_q  <= {SC_W{1'b0}};
            relax_cnt_q <= {RC_W{1'b0}};
        end else begin
            state_q     <= state_d;
            launch_q    <= launch_d;
            valid_q     <= valid_d;
            meas_q      <= meas_d;
            ovf_q       <= ovf_d;
            bub_q       <= bub_d;
            busy_q      <= busy_d;
            sync_cnt_q  <= sync_cnt_d;
            relax_cnt_q <= relax_cnt_d;
        end
    end

    // Next-state and next-output logic for the capture sequence.
    always_comb begin
        state_d     = state_q;
        launch_d    = launch_q;
        valid_d     = valid_q;
        meas_d      = meas_q;
        ovf_d       = ovf_q;
        bub_d       = bub_q;
        sync_cnt_d  = sync_cnt_q;
        relax_cnt_d = relax_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start && ena) begin
                    state_d  = ST_LAUNCH;
                    launch_d = 1'b1;
                end else begin
                    launch_d = 1'b0;
                end
            end
            ST_LAUNCH: begin
                // This edge loads the capture flop; the counter then spans
                // the remaining stages plus the encode/register edge.
                state_d    = ST_SYNC;
                sync_cnt_d = SC_W'(SYNC_STAGES - 1);
            end
            ST_SYNC: begin
                if (sync_cnt_q == {SC_W{1'b0}}) begin
                    state_d  = ST_HOLD;
                    meas_d   = enc_count_s;
                    ovf_d    = enc_ovf_s;
                    bub_d    = enc_bub_s;
                    valid_d  = 1'b1;
                    launch_d = 1'b0;
                end else begin
                    sync_cnt_d = sync_cnt_q - SC_W'(1);
                end
            end
            ST_HOLD: begin
                // Result fields are left untouched so they stay stable, and
                // meas keeps its value after acceptance.
                if (valid_q && res.meas_ready) begin
                    valid_d     = 1'b0;
                    state_d     = ST_RELAX;
                    relax_cnt_d = RC_W'(RELAX_CYC - 1);
                end else begin
                    valid_d = valid_q;
                end
            end
            ST_RELAX: begin
                launch_d = 1'b0;
                if (relax_cnt_q == {RC_W{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    relax_cnt_d = relax_cnt_q - RC_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                launch_d = 1'b0;
                valid_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign launch         = launch_q;
    assign busy           = busy_q;
    assign res.meas       = meas_q;
    assign res.meas_valid = valid_q;
    assign res.overflow   = ovf_q;
    assign res.bubble_err = bub_q;

endmodule

// File: tb/tb_tdc_capture.sv
module tb_tdc_capture;
    import tdc_pkg::*;

    localparam int N  = 64;
    localparam int OW = 7;

    typedef struct {
        logic [OW-1:0] meas;
        logic          ovf;
        logic          bub;
        int            cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        start = 1'b0;
    logic        launch;
    logic        busy;
    logic [63:0] dl_out = 64'd0;

    logic        start_inv = 1'b0;
    logic        launch_inv;
    logic        busy_inv;
    logic [63:0] dl_inv = 64'd0;

    tdc_capture_if #(.OUT_W(OW)) res_if ();
    tdc_capture_if #(.OUT_W(OW)) inv_if ();

    tdc_capture #(.N(N), .OUT_W(OW), .SYNC_STAGES(2), .RELAX_CYC(4), .INVERT(0)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .launch(launch),
        .dl_out(dl_out), .busy(busy), .res(res_if.master)
    );

    tdc_capture #(.N(N), .OUT_W(OW), .SYNC_STAGES(2), .RELAX_CYC(4), .INVERT(1)) dut_inv (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_inv), .launch(launch_inv),
        .dl_out(dl_inv), .busy(busy_inv), .res(inv_if.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: count ones; a clean thermometer code is 2^k-1, i.e. v&(v+1)==0.
    function automatic exp_t model(input logic [63:0] v, input int at_cyc);
        exp_t e;
        e.meas = OW'($countones(v));
        e.ovf  = (v == ~64'd0);
        e.bub  = ((v & (v + 64'd1)) != 64'd0);
        e.cyc  = at_cyc;
        return e;
    endfunction

    // Monitor: pop on each new result, check it, then check it stays put.
    initial begin
        logic          vprev;
        logic [OW-1:0] h_meas;
        logic          h_ovf;
        logic          h_bub;
        exp_t          e;
        vprev = 1'b0;
        h_meas = '0; h_ovf = 1'b0; h_bub = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                vprev = 1'b0;
            end else if (res_if.meas_valid) begin
                check("launch_low_while_valid", 64'(launch), 64'd0);
                if (!vprev) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_valid: got meas %0d with no pending request", res_if.meas);
                    end else begin
                        e = sb.pop_front();
                        check("meas",       64'(res_if.meas),       64'(e.meas));
                        check("overflow",   64'(res_if.overflow),   64'(e.ovf));
                        check("bubble_err", 64'(res_if.bubble_err), 64'(e.bub));
                        check("latency",    64'(cyc),               64'(e.cyc));
                    end
                    h_meas = res_if.meas; h_ovf = res_if.overflow; h_bub = res_if.bubble_err;
                end else begin
                    check("hold_meas", 64'(res_if.meas), 64'(h_meas));
                    check("hold_ovf",  64'(res_if.overflow), 64'(h_ovf));
                    check("hold_bub",  64'(res_if.bubble_err), 64'(h_bub));
                end
                vprev = 1'b1;
            end else begin
                vprev = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = !busy;
        end
        check("wait_idle", 64'(ok), 64'd1);
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = res_if.meas_valid;
        end
        check("valid_seen", 64'(got), 64'd1);
    endtask

    // One measurement: start pulse, optional ready delay, relax timing checks.
    task automatic run_meas(input logic [63:0] v, input int rdy_dly, input bit drop_ena);
        bit got;
        wait_idle();
        @(posedge clk); #1;
        dl_out = v; start = 1'b1; ena = 1'b1;
        res_if.meas_ready = (rdy_dly == 0);
        sb.push_back(model(v, cyc + 4));
        @(posedge clk); #1;
        start = 1'b0;
        check("launch_e0", 64'(launch), 64'd1);
        check("busy_e0", 64'(busy), 64'd1);
        if (drop_ena) ena = 1'b0;
        wait_valid(got);
        for (int i = 0; i < rdy_dly; i++) @(negedge clk);
        res_if.meas_ready = 1'b1;
        @(posedge clk); #1;
        check("valid_drop", 64'(res_if.meas_valid), 64'd0);
        res_if.meas_ready = 1'b0;
        ena = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("busy_relax", 64'(busy), 64'd1);
            check("launch_relax", 64'(launch), 64'd0);
        end
        @(posedge clk); #1;
        check("busy_clear", 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        bit          got;
        int          k;
        int          h;

        res_if.meas_ready = 1'b0;
        inv_if.meas_ready = 1'b1;
        dl_out = ~64'd0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_launch", 64'(launch), 64'd0);
        check("rst_valid",  64'(res_if.meas_valid), 64'd0);
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_meas",   64'(res_if.meas), 64'd0);
        rst_n = 1'b1;
        ena = 1'b1;

        // Idle with all taps set and no start.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_launch", 64'(launch), 64'd0);
            check("idle_valid",  64'(res_if.meas_valid), 64'd0);
            check("idle_busy",   64'(busy), 64'd0);
        end

        // Directed patterns.
        run_meas(64'h0000_0000_0000_03FF, 0, 1'b0);
        run_meas(~64'd0, 1, 1'b0);
        run_meas(64'd0, 0, 1'b0);
        run_meas(64'h0000_0000_0000_00F7, 2, 1'b0);
        run_meas(64'h0000_0000_0000_03FF, 0, 1'b1);

        // start ignored while ena is low.
        wait_idle();
        ena = 1'b0; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ena_low_launch", 64'(launch), 64'd0);
            check("ena_low_busy",   64'(busy), 64'd0);
        end
        start = 1'b0; ena = 1'b1;

        // Backpressure with a start pulse in HOLD, then start held through RELAX.
        wait_idle();
        v = 64'h0000_0000_00FF_FFFF;
        @(posedge clk); #1;
        dl_out = v; start = 1'b1; res_if.meas_ready = 1'b0;
        sb.push_back(model(v, cyc + 4));
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid(got);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) start = 1'b1;
            if (i == 6) start = 1'b0;
            @(negedge clk);
            check("bp_valid_held", 64'(res_if.meas_valid), 64'd1);
        end
        res_if.meas_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        h = cyc;
        res_if.meas_ready = 1'b0;
        check("bp_valid_drop", 64'(res_if.meas_valid), 64'd0);
        sb.push_back(model(v, h + 5 + 3));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("bp_no_early_launch", 64'(launch), 64'd0);
        end
        @(posedge clk); #1;
        check("bp_relaunch", 64'(launch), 64'd1);
        start = 1'b0;
        res_if.meas_ready = 1'b1;
        wait_valid(got);
        @(posedge clk); #1;
        res_if.meas_ready = 1'b0;

        // Randomized measurements.
        for (int it = 0; it < 16; it++) begin
            k = $urandom_range(0, 64);
            v = (k == 64) ? ~64'd0 : ((64'd1 << k) - 64'd1);
            case ($urandom_range(0, 2))
                0: ;
                1: if (k >= 2) v[$urandom_range(0, k - 2)] = 1'b0;
                default: v = {$urandom, $urandom};
            endcase
            run_meas(v, $urandom_range(0, 3), it[0]);
        end

        // Reset during SYNC discards the pending result.
        wait_idle();
        @(posedge clk); #1;
        dl_out = 64'h0000_0000_0000_000F; start = 1'b1;
        sb.push_back(model(dl_out, cyc + 4));
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        check("rst_mid_launch", 64'(launch), 64'd0);
        check("rst_mid_busy",   64'(busy), 64'd0);
        check("rst_mid_valid",  64'(res_if.meas_valid), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_valid", 64'(res_if.meas_valid), 64'd0);
        end
        check("post_rst_meas", 64'(res_if.meas), 64'd0);

        // Active-low taps on the inverting instance.
        @(posedge clk); #1;
        dl_inv = ~64'hFF; start_inv = 1'b1;
        @(posedge clk); #1;
        start_inv = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = inv_if.meas_valid;
        end
        check("inv_valid_seen", 64'(got), 64'd1);
        check("inv_meas", 64'(inv_if.meas), 64'd8);
        check("inv_ovf",  64'(inv_if.overflow), 64'd0);
        check("inv_bub",  64'(inv_if.bubble_err), 64'd0);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
